// File: rtl/echo_responder.sv
// Echo responder: pops one word from an upstream FIFO, waits `delay` cycles, then
// indicates it downstream with a wrapping sequence tag. Define ECHO_RESPONDER_STATS_EN for counters.
module echo_responder #(
  parameter int DATA_W = 32,
  parameter int SEQ_W  = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] src_first,
  input  logic              src_first__RDY,
  input  logic              src_deq__RDY,
  output logic              src_deq__ENA,
  input  logic [3:0]        delay,
  output logic              ind_heard__ENA,
  output logic [DATA_W-1:0] ind_heard_v,
  output logic [SEQ_W-1:0]  ind_heard_seq,
  input  logic              ind_heard__RDY
`ifdef ECHO_RESPONDER_STATS_EN
  ,
  output logic [15:0]       stat_echoed,
  output logic [15:0]       stat_stall
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  state_t              w_load_state;
  logic [DATA_W-1:0]   r_hold;
  logic [3:0]          r_cnt;
  logic [SEQ_W-1:0]    r_seq;
  logic                w_send_fire;
  logic                w_pop;

  // NOTE: RST gates the strobes so nothing fires during reset, even before the
  // first reset edge has forced the state register to IDLE.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_send_fire = 1'b0;
    w_pop       = 1'b0;
    if (!RST) begin
      w_send_fire = (r_state == SEND) && ind_heard__RDY;
      w_pop       = src_first__RDY && src_deq__RDY &&
                    ((r_state == IDLE) || w_send_fire);
    end
  end

  assign w_load_state = (delay == 4'd0) ? SEND : WAIT;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_pop) w_state_nxt = w_load_state;
      WAIT: if (r_cnt <= 4'd1) w_state_nxt = SEND;
      SEND: if (w_send_fire) w_state_nxt = w_pop ? w_load_state : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      // NOTE: the hold register is cleared on reset because its value is
      // visible on ind_heard_v and must read zero after reset.
      r_hold  <= '0;
      r_cnt   <= '0;
      r_seq   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pop) begin
        r_hold <= src_first;
        r_cnt  <= delay;
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_send_fire) r_seq <= r_seq + SEQ_W'(1);
    end
  end

  always_comb begin
    src_deq__ENA   = w_pop;
    ind_heard__ENA = w_send_fire;
    ind_heard_v    = r_hold;
    ind_heard_seq  = r_seq;
  end

`ifdef ECHO_RESPONDER_STATS_EN
  logic [15:0] r_stat_echoed;
  logic [15:0] r_stat_stall;

  // Both counters saturate rather than wrap.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_stat_echoed <= '0;
      r_stat_stall  <= '0;
    end else begin
      if (w_send_fire && (r_stat_echoed != 16'hFFFF))
        r_stat_echoed <= r_stat_echoed + 16'd1;
      if ((r_state == SEND) && !ind_heard__RDY && (r_stat_stall != 16'hFFFF))
        r_stat_stall <= r_stat_stall + 16'd1;
    end
  end

  assign stat_echoed = r_stat_echoed;
  assign stat_stall  = r_stat_stall;
`endif

endmodule

// File: tb/tb_echo_responder.sv
// Self-checking bench for echo_responder: directed scenarios with a scoreboard of
// expected {payload, seq} pairs compared whenever the DUT indicates.
module tb_echo_responder;

  typedef struct packed {
    logic [31:0] v;
    logic [7:0]  seq;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] src_first;
  logic        src_first__RDY;
  logic        src_deq__RDY;
  logic        src_deq__ENA;
  logic [3:0]  delay;
  logic        ind_heard__ENA;
  logic [31:0] ind_heard_v;
  logic [7:0]  ind_heard_seq;
  logic        ind_heard__RDY;
`ifdef ECHO_RESPONDER_STATS_EN
  logic [15:0] stat_echoed;
  logic [15:0] stat_stall;
`endif

  int          n_asserts = 0;
  int          n_fails   = 0;
  exp_t        sb[$];
  exp_t        mon_e;
  logic [7:0]  exp_seq = 8'd0;
  logic [7:0]  stall_seq;

  echo_responder #(.DATA_W(32), .SEQ_W(8)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .src_first      (src_first),
    .src_first__RDY (src_first__RDY),
    .src_deq__RDY   (src_deq__RDY),
    .src_deq__ENA   (src_deq__ENA),
    .delay          (delay),
    .ind_heard__ENA (ind_heard__ENA),
    .ind_heard_v    (ind_heard_v),
    .ind_heard_seq  (ind_heard_seq),
    .ind_heard__RDY (ind_heard__RDY)
`ifdef ECHO_RESPONDER_STATS_EN
    ,
    .stat_echoed    (stat_echoed),
    .stat_stall     (stat_stall)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_asserts++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] w);
    sb.push_back('{v: w, seq: exp_seq});
    exp_seq = exp_seq + 8'd1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    repeat (2) tick();
    @(negedge CLK);
    check("rst_deq_ena", src_deq__ENA, 1'b0);
    check("rst_ind_ena", ind_heard__ENA, 1'b0);
    check("rst_v", ind_heard_v, 32'h0);
    check("rst_seq", ind_heard_seq, 8'h0);
`ifdef ECHO_RESPONDER_STATS_EN
    check("rst_stat_echoed", stat_echoed, 16'h0);
    check("rst_stat_stall", stat_stall, 16'h0);
`endif
    tick();
    RST = 1'b0;
    src_first__RDY = 1'b0;
    sb.delete();
    exp_seq = 8'd0;
  endtask

  // Scoreboard monitor: every indication must match the oldest expected entry.
  always @(negedge CLK) begin
    if (!RST) begin
      check("ind_without_rdy", ind_heard__ENA & ~ind_heard__RDY, 1'b0);
      check("deq_without_rdy", src_deq__ENA & ~(src_deq__RDY & src_first__RDY), 1'b0);
      if (ind_heard__ENA) begin
        if (sb.size() == 0) begin
          check("unexpected_ind", ind_heard__ENA, 1'b0);
        end else begin
          mon_e = sb.pop_front();
          check("ind_v", ind_heard_v, mon_e.v);
          check("ind_seq", ind_heard_seq, mon_e.seq);
        end
      end
    end
  end

  initial begin
    RST            = 1'b1;
    src_first      = 32'h0;
    src_first__RDY = 1'b1;
    src_deq__RDY   = 1'b1;
    ind_heard__RDY = 1'b1;
    delay          = 4'd0;
    do_reset();

    // Single word, zero delay: pop at t, indication at t+1.
    src_first = 32'h12345678; delay = 4'd0; src_first__RDY = 1'b1;
    @(negedge CLK); check("t1_pop", src_deq__ENA, 1'b1); push_exp(src_first);
    tick(); src_first__RDY = 1'b0;
    @(negedge CLK); check("t1_ind", ind_heard__ENA, 1'b1);
    tick();
    @(negedge CLK); check("t1_idle", ind_heard__ENA, 1'b0);
    tick();

    // delay=3: three WAIT cycles; changing delay mid-flight has no effect.
    src_first = 32'hA5A5A5A5; delay = 4'd3; src_first__RDY = 1'b1;
    @(negedge CLK); check("t2_pop", src_deq__ENA, 1'b1); push_exp(src_first);
    tick(); src_first__RDY = 1'b0; delay = 4'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK); check("t2_wait", ind_heard__ENA, 1'b0);
      tick();
    end
    @(negedge CLK); check("t2_ind", ind_heard__ENA, 1'b1);
    tick();

    // Downstream stall for 5 cycles with the next word waiting upstream.
    ind_heard__RDY = 1'b0; src_first = 32'h11110001; delay = 4'd0; src_first__RDY = 1'b1;
    @(negedge CLK); check("t3_pop", src_deq__ENA, 1'b1); push_exp(src_first);
    stall_seq = exp_seq - 8'd1;
    tick(); src_first = 32'h22220002;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("t3_no_deq", src_deq__ENA, 1'b0);
      check("t3_no_ind", ind_heard__ENA, 1'b0);
      check("t3_hold_v", ind_heard_v, 32'h11110001);
      check("t3_hold_seq", ind_heard_seq, stall_seq);
      tick();
    end
    ind_heard__RDY = 1'b1;
    @(negedge CLK);
    check("t3_ind", ind_heard__ENA, 1'b1);
    check("t3_pop_same_cycle", src_deq__ENA, 1'b1);
    push_exp(src_first);
    tick(); src_first__RDY = 1'b0;
    @(negedge CLK); check("t3_ind2", ind_heard__ENA, 1'b1);
    tick();
`ifdef ECHO_RESPONDER_STATS_EN
    @(negedge CLK);
    check("t3_stat_stall", stat_stall, 16'd5);
    check("t3_stat_echoed", stat_echoed, 16'd4);
    tick();
`endif

    // 300-word stream, one word per cycle, seq wraps at 256.
    do_reset();
    src_first__RDY = 1'b1; delay = 4'd0;
    for (int i = 0; i < 300; i++) begin
      src_first = (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0000;
      @(negedge CLK);
      check("t4_pop", src_deq__ENA, 1'b1);
      if (i > 0) check("t4_ind", ind_heard__ENA, 1'b1);
      if (i == 256) check("t4_seq_ff", ind_heard_seq, 8'hFF);
      if (i == 257) check("t4_seq_wrap", ind_heard_seq, 8'h00);
      push_exp(src_first);
      tick();
    end
    src_first__RDY = 1'b0;
    @(negedge CLK);
    check("t4_last_ind", ind_heard__ENA, 1'b1);
    check("t4_last_seq", ind_heard_seq, 8'd43);
    tick();
    @(negedge CLK); check("t4_idle", ind_heard__ENA, 1'b0);
`ifdef ECHO_RESPONDER_STATS_EN
    check("t4_stat_echoed", stat_echoed, 16'd300);
`endif
    tick();

    // Reset during WAIT discards the held word; next word restarts at seq 0.
    src_first = 32'hDEADBEEF; delay = 4'd5; src_first__RDY = 1'b1;
    @(negedge CLK); check("t5_pop", src_deq__ENA, 1'b1);
    tick(); src_first__RDY = 1'b0;
    tick();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK); check("t5_no_ind", ind_heard__ENA, 1'b0);
      tick();
    end
    src_first = 32'h0BADF00D; delay = 4'd0; src_first__RDY = 1'b1; src_deq__RDY = 1'b0;
    @(negedge CLK); check("t5_deq_rdy_low", src_deq__ENA, 1'b0);
    tick(); src_deq__RDY = 1'b1;
    @(negedge CLK); check("t5_pop2", src_deq__ENA, 1'b1); push_exp(src_first);
    tick(); src_first__RDY = 1'b0;
    @(negedge CLK);
    check("t5_ind", ind_heard__ENA, 1'b1);
    check("t5_seq0", ind_heard_seq, 8'h00);
    tick();
    @(negedge CLK);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
